fast_corner_collector: RTL
==========================

# fast_corner_collector

Downstream sink for `FAST_with_NMS`. It captures every asserted `iscorner` together with its `x_coord`/`y_coord` into an on-chip FIFO, and inserts an end-of-frame token on each `frame_end` pulse. It presents the stream to a consumer over a valid/ready handshake. It also reports per-frame corner counts and drop/overflow status for the host or readout logic.

## Interface
- `DEPTH`, 64: FIFO entries, power of two, ≥4.
- `COORD_W`, 10: coordinate width, matches FAST output.
- `MAX_CORNERS`, 1023: per-frame cap; corners beyond this are dropped.
- `CNT_W`, 16: width of the counters.

- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `ce`  in  1  capture enable; when low, `iscorner`/`frame_end` are ignored; readout continues.
- `iscorner`  in  1  corner strobe from `FAST_with_NMS`.
- `x_coord`  in  COORD_W  corner column, valid with `iscorner`.
- `y_coord`  in  COORD_W  corner row, valid with `iscorner`.
- `frame_end`  in  1  one-cycle pulse after the last pixel of a frame, from the pixel source.
- `clr_ovf`  in  1  clears `overflow` and `drop_count`.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_eof`  out  1  head is an end-of-frame token; for an EOF token, `out_x`/`out_y` are 0.
- `out_x`  out  COORD_W  head column.
- `out_y`  out  COORD_W  head row.
- `frame_corners`  out  CNT_W  accepted corners of the last completed frame.
- `drop_count`  out  CNT_W  dropped corners, saturating.
- `overflow`  out  1  sticky: at least one corner dropped.

## Operation
- Entry format: `{eof, x, y}`, 1+2·COORD_W bits.
- Corner push: `ce && iscorner`, `occupancy ≤ DEPTH-2`, and `cur_cnt < MAX_CORNERS` → write `{0,x,y}` and increment `cur_cnt`.
  - If any of these conditions fails, the corner is dropped: set `overflow` and increment `drop_count` (saturating at all-ones).
- EOF token: `ce && frame_end` sets `eof_pend`.
  - Each cycle that `eof_pend` is set and no corner push occurs, and `occupancy < DEPTH`: write `{1,0,0}`, clear `eof_pend`, latch `frame_corners <= cur_cnt`, and clear `cur_cnt` to 0.
  - The reserved slot (corners stop at DEPTH-1 occupancy) guarantees the EOF token is never lost.
- Same-cycle `iscorner` and `frame_end`: the corner is written this cycle and the EOF token next cycle. The corner counts toward the ending frame.
- `frame_end` while `eof_pend` is already set: the pulses merge (one token).
- Pop: `out_valid && out_ready`. Push and pop in the same cycle are both honoured at any occupancy, including full.
- `clr_ovf` has priority over a same-cycle drop: the counter ends at 0, and `overflow` ends at 0.

## Timing
- Reset values: `out_valid=0`, `out_eof=0`, `out_x=0`, `out_y=0`, `frame_corners=0`, `drop_count=0`, `overflow=0`; FIFO empty, `eof_pend=0`, `cur_cnt=0`.
- Latency: a push at edge N gives `out_valid=1` after edge N+1 when the FIFO was empty (registered head, 1-cycle fall-through).
- Sustained throughput: 1 entry/cycle both sides.
- `out_*` hold stable while `out_valid && !out_ready`.
- `frame_corners` updates at the same edge the EOF token is written.
- Pointers wrap modulo DEPTH; occupancy is a log2(DEPTH)+1-bit counter.
- `rst` mid-operation: all state clears immediately, and contents are discarded.

## Structure
- Package `fast_pkg`: `COORD_W`, and the `corner_entry_t` packed struct `{eof, x, y}`, shared with `FAST_with_NMS` users.
- Sub-module `fast_sync_fifo` (parametric width/depth, registered output, occupancy port).
- Admission, EOF, and counter logic live in the top level.

## Test plan
1. Three corners (5,3), (12,3), (7,9), then `frame_end`, with `out_ready=1` → stream of 3 corners, then an EOF entry; `frame_corners=3`; `overflow=0`.
2. `out_ready=0`, 70 consecutive corners (DEPTH=64), then `frame_end` → 63 corners stored, then EOF fills slot 64; `drop_count=7`; `overflow=1`; draining yields 63 corners and 1 EOF.
3. `iscorner` and `frame_end` in the same cycle at (29,19) → corner entry, then EOF on the next edge; `frame_corners` includes it.
4. MAX_CORNERS=4, 6 corners in one frame → 4 entries; `drop_count=2`; next frame's counter restarts at 0.
5. `ce=0` with corners and `frame_end` pulses → no writes; existing entries still drain with `out_ready=1`.
6. Assert `rst` with 10 entries queued → next cycle `out_valid=0` and all counters 0; a new corner appears after 2 edges.

Source files
------------

// File: rtl/fast_pkg.sv
// Corner-stream entry format shared by FAST_with_NMS producers and consumers.
package fast_pkg;

    localparam int COORD_W = 10;

    typedef struct packed {
        logic               eof;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } corner_entry_t;

    localparam int ENTRY_W = $bits(corner_entry_t);

    function automatic corner_entry_t make_corner(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        corner_entry_t e;
        e.eof = 1'b0;
        e.x   = x;
        e.y   = y;
        return e;
    endfunction

    function automatic corner_entry_t make_eof();
        corner_entry_t e;
        e     = '0;
        e.eof = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/fast_corner_collector_if.sv
// Corner capture inputs plus the valid/ready readout stream of the collector.
interface fast_corner_collector_if #(
    parameter int COORD_W = fast_pkg::COORD_W
);
    logic               ce;
    logic               iscorner;
    logic [COORD_W-1:0] x_coord;
    logic [COORD_W-1:0] y_coord;
    logic               frame_end;
    logic               out_valid;
    logic               out_ready;
    logic               out_eof;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;

    modport master (
        output ce, iscorner, x_coord, y_coord, frame_end, out_ready,
        input  out_valid, out_eof, out_x, out_y
    );

    modport slave (
        input  ce, iscorner, x_coord, y_coord, frame_end, out_ready,
        output out_valid, out_eof, out_x, out_y
    );
endinterface

// File: rtl/fast_sync_fifo.sv
// Synchronous FIFO with a registered head: one extra cycle from write to rd_valid.
// Full-throughput; a write while full is accepted only together with a read.
module fast_sync_fifo #(
    parameter  int WIDTH = 21,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    occupancy
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d, avail;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push, pop;

    // The head register only ever loads entries written at an earlier edge,
    // so the async memory read never sees a same-cycle write.
    always_comb begin
        pop      = rd_en && valid_q;
        push     = wr_en && ((count_q < CW'(DEPTH)) || pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        avail    = count_q - CW'(pop);
        valid_d  = (avail != '0);
        head_d   = valid_d ? mem_q[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    assign rd_valid  = valid_q;
    assign rd_data   = head_q;
    assign occupancy = count_q;

endmodule

// File: rtl/fast_corner_collector.sv
// Queues FAST corners and end-of-frame tokens for a valid/ready consumer; head appears
// one cycle after the write. Corners are dropped (and counted) when full or over the cap.
module fast_corner_collector #(
    parameter  int DEPTH       = 64,
    parameter  int COORD_W     = fast_pkg::COORD_W,
    parameter  int MAX_CORNERS = 1023,
    parameter  int CNT_W       = 16,
    localparam int CW          = $clog2(DEPTH) + 1,
    localparam int ENTRY_W     = 1 + 2 * COORD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    fast_corner_collector_if.slave   bus,
    input  logic                     clr_ovf,
    output logic [CNT_W-1:0]         frame_corners,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow
);
    import fast_pkg::*;

    logic [COORD_W-1:0] cx, cy;
    logic [CW-1:0]      occ;
    logic               head_vld;
    logic [ENTRY_W-1:0] head_raw;
    corner_entry_t      head, wr_entry;
    logic               wr_en;

    logic               eof_pend_q, eof_pend_d;
    logic [CNT_W-1:0]   cur_cnt_q, cur_cnt_d;
    logic [CNT_W-1:0]   frame_corners_q, frame_corners_d;
    logic [CNT_W-1:0]   drop_count_q, drop_count_d;
    logic               overflow_q, overflow_d;

    logic               corner_req, corner_push, drop, eof_push;

    assign cx = bus.x_coord;
    assign cy = bus.y_coord;

    // Corners stop one slot short of full so a pending EOF token always has room.
    always_comb begin
        corner_req  = bus.ce && bus.iscorner;
        corner_push = corner_req && (occ <= CW'(DEPTH - 2))
                      && (cur_cnt_q < CNT_W'(MAX_CORNERS));
        drop        = corner_req && !corner_push;
        eof_push    = eof_pend_q && !corner_push && (occ < CW'(DEPTH));
        wr_en       = corner_push || eof_push;
        wr_entry    = corner_push ? make_corner(cx, cy) : make_eof();

        eof_pend_d  = eof_pend_q ? !eof_push : (bus.ce && bus.frame_end);

        cur_cnt_d       = eof_push ? '0 : cur_cnt_q + CNT_W'(corner_push);
        frame_corners_d = eof_push ? cur_cnt_q : frame_corners_q;

        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        if (clr_ovf) begin
            drop_count_d = '0;
            overflow_d   = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eof_pend_q      <= 1'b0;
            cur_cnt_q       <= '0;
            frame_corners_q <= '0;
            drop_count_q    <= '0;
            overflow_q      <= 1'b0;
        end else begin
            eof_pend_q      <= eof_pend_d;
            cur_cnt_q       <= cur_cnt_d;
            frame_corners_q <= frame_corners_d;
            drop_count_q    <= drop_count_d;
            overflow_q      <= overflow_d;
        end
    end

    fast_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_entry),
        .rd_en     (bus.out_ready),
        .rd_valid  (head_vld),
        .rd_data   (head_raw),
        .occupancy (occ)
    );

    assign head          = head_raw;
    assign bus.out_valid = head_vld;
    assign bus.out_eof   = head.eof;
    assign bus.out_x     = head.x;
    assign bus.out_y     = head.y;

    assign frame_corners = frame_corners_q;
    assign drop_count    = drop_count_q;
    assign overflow      = overflow_q;

endmodule
